pio_pad_arbiter: RTL and testbench
==================================

PIO_PAD_ARBITER -- requirements
Module: pio_pad_arbiter

Interface
REQ-001 SHALL have parameter TURN_CYC, default 2, which sets the high-Z turnaround cycles before a grant (legal range 1..7).
REQ-002 SHALL have parameter MAX_OWN, default 16, which sets the maximum consecutive OWN cycles per grant (legal range 2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port req, input, 2 bits: per-requester pad ownership request, level, held for the whole transaction.
REQ-006 SHALL have port wr, input, 2 bits: per-requester direction while owning (1 = drive pad, 0 = listen).
REQ-007 SHALL have port dout, input, 2 bits: per-requester bit to drive.
REQ-008 SHALL have port gnt, output, 2 bits: one-hot-or-zero grant, registered.
REQ-009 SHALL have port tmo, output, 1 bit: one-cycle pulse on forced release.
REQ-010 SHALL have port din, output, 1 bit: synchronized pad value shared by both requesters.
REQ-011 SHALL have port pad_i, input, 1 bit: from the BB O pin.
REQ-012 SHALL have port pad_o, output, 1 bit: to the BB I pin, registered.
REQ-013 SHALL have port pad_t, output, 1 bit: to the BB T pin (1 = high-Z), registered.

Function
REQ-014 SHALL implement FSM states IDLE, TURN, OWN, RELEASE; at most one requester (owner k) is tracked from TURN through RELEASE.
REQ-015 SHALL, in IDLE, treat a requester as eligible when req[i]=1 and mask[i]=0; with no eligible requester, SHALL stay in IDLE.
REQ-016 SHALL arbitrate round-robin: if both are eligible, pick the requester other than last; if only one is eligible, pick it; on the IDLE->TURN edge SHALL load last=k and turn_cnt=TURN_CYC-1.
REQ-017 SHALL, in TURN, hold gnt=0 and pad_t=1 and decrement turn_cnt; at turn_cnt=0 SHALL move to OWN; if req[k]=0 in any TURN cycle, SHALL return to IDLE with no grant.
REQ-018 SHALL make gnt[k]=1 exactly in cycles where state==OWN, and gnt=0 in all other cycles.
REQ-019 SHALL clear own_cnt to 0 on OWN entry and increment it each OWN cycle (8-bit, never wraps within legal MAX_OWN).
REQ-020 SHALL, in an OWN cycle with req[k]=1, wr[k]=1 and no timeout, register next pad_t=0 and pad_o=dout[k]; otherwise SHALL register next pad_t=1 and leave pad_o at its held value.
REQ-021 SHALL, in OWN with req[k]=0, move to RELEASE, so gnt falls and pad_t=1 on the following edge.
REQ-022 SHALL, in OWN with req[k]=1 and own_cnt==MAX_OWN-1, move to RELEASE, set tmo=1 for exactly one cycle, and set mask[k]=1.
REQ-023 SHALL clear mask[i] in any cycle where req[i]=0; while mask[i]=1, req[i] is ignored.
REQ-024 SHALL spend exactly one cycle in RELEASE with pad_t=1 and gnt=0, then go to IDLE, so at least TURN_CYC+1 high-Z cycles separate any two owners.
REQ-025 SHALL drive din through a two-flop synchronizer on pad_i, giving a 2-cycle latency independent of state.
REQ-026 SHALL ignore changes on req, wr and dout of the non-owner outside IDLE.

Reset
REQ-027 SHALL, on a clk edge with rst_n=0, set state=IDLE, gnt=0, tmo=0, pad_t=1, pad_o=0, din and sync flops=0, mask=0, last=1 (requester 0 wins first), and clear turn_cnt and own_cnt.
REQ-028 SHALL, on reset asserted mid-OWN, have pad_t=1 and gnt=0 on the cycle after the reset edge.

Verification
REQ-029 SHALL cover: req=01 after reset, wr[0]=1, dout[0]=1 -> gnt=01 three cycles after the req sample (2 TURN + entry); pad_t=0 and pad_o=1 one cycle after gnt.
REQ-030 SHALL cover: req=11 from IDLE after reset -> gnt=01 first; drop req[0] -> RELEASE, 3 high-Z cycles, then gnt=10.
REQ-031 SHALL cover: req=01 held with MAX_OWN=16 -> gnt=01 for exactly 16 cycles, tmo pulse 1 cycle, and no re-grant to 0 until req[0] drops and rises again.
REQ-032 SHALL cover: req[1] dropped during TURN -> no gnt, return to IDLE, pad_t stays 1.
REQ-033 SHALL cover: pad_i toggled 0->1 -> din=1 exactly two cycles later in any state.
REQ-034 SHALL cover: rst_n=0 during OWN with pad_t=0 -> pad_t=1 and gnt=00 next cycle; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/pio_pad_arbiter.sv
// Two-requester arbiter for a single bidirectional pad: round-robin grant after a
// high-Z turnaround, forced release after MAX_OWN cycles, and a synchronized input path.
module pio_pad_arbiter #(
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned MAX_OWN  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] wr,
    input  logic [1:0] dout,
    output logic [1:0] gnt,
    output logic       tmo,
    output logic       din,
    input  logic       pad_i,
    output logic       pad_o,
    output logic       pad_t
);

    typedef enum logic [1:0] {IDLE, TURN, OWN, RELEASE} state_e;

    localparam logic [2:0] TURN_LOAD = 3'(TURN_CYC - 1);
    localparam logic [7:0] OWN_LAST  = 8'(MAX_OWN - 1);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [1:0] mask_q, mask_d;
    logic [2:0] turn_cnt_q, turn_cnt_d;
    logic [7:0] own_cnt_q, own_cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic       tmo_q, tmo_d;
    logic       pad_o_q, pad_o_d;
    logic       pad_t_q, pad_t_d;
    logic       sync_q, din_q;

    logic [1:0] elig;
    logic       pick;

    assign elig = req & ~mask_q;
    assign pick = (elig == 2'b11) ? ~last_q : elig[1];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        mask_d     = mask_q & req;
        turn_cnt_d = turn_cnt_q;
        own_cnt_d  = own_cnt_q;
        tmo_d      = 1'b0;
        pad_o_d    = pad_o_q;
        pad_t_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (elig != 2'b00) begin
                    state_d    = TURN;
                    owner_d    = pick;
                    last_d     = pick;
                    turn_cnt_d = TURN_LOAD;
                end
            end
            TURN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (turn_cnt_q == 3'd0) begin
                    state_d   = OWN;
                    own_cnt_d = 8'd0;
                end else begin
                    turn_cnt_d = turn_cnt_q - 3'd1;
                end
            end
            OWN: begin
                own_cnt_d = own_cnt_q + 8'd1;
                if (!req[owner_q]) begin
                    state_d = RELEASE;
                end else if (own_cnt_q == OWN_LAST) begin
                    // Masking the owner keeps a stuck requester from winning again until it drops req.
                    state_d         = RELEASE;
                    tmo_d           = 1'b1;
                    mask_d[owner_q] = 1'b1;
                end else if (wr[owner_q]) begin
                    pad_t_d = 1'b0;
                    pad_o_d = dout[owner_q];
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_d = (state_d == OWN) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            mask_q     <= 2'b00;
            turn_cnt_q <= 3'd0;
            own_cnt_q  <= 8'd0;
            gnt_q      <= 2'b00;
            tmo_q      <= 1'b0;
            pad_o_q    <= 1'b0;
            pad_t_q    <= 1'b1;
            sync_q     <= 1'b0;
            din_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            mask_q     <= mask_d;
            turn_cnt_q <= turn_cnt_d;
            own_cnt_q  <= own_cnt_d;
            gnt_q      <= gnt_d;
            tmo_q      <= tmo_d;
            pad_o_q    <= pad_o_d;
            pad_t_q    <= pad_t_d;
            sync_q     <= pad_i;
            din_q      <= sync_q;
        end
    end

    assign gnt   = gnt_q;
    assign tmo   = tmo_q;
    assign din   = din_q;
    assign pad_o = pad_o_q;
    assign pad_t = pad_t_q;

endmodule

// File: tb/tb_pio_pad_arbiter.sv
// Self-checking bench for pio_pad_arbiter: fixed vector table, directed corner
// sequences and a randomized run against a phase/age reference model.
module tb_pio_pad_arbiter;

    localparam int TURN_CYC = 2;
    localparam int MAX_OWN  = 16;

    localparam int M_IDLE = 0;
    localparam int M_TURN = 1;
    localparam int M_OWN  = 2;
    localparam int M_REL  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, wr, dout;
    logic [1:0] gnt;
    logic       tmo, din, pad_i, pad_o, pad_t;

    int checks = 0;
    int errors = 0;

    pio_pad_arbiter #(.TURN_CYC(TURN_CYC), .MAX_OWN(MAX_OWN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .wr   (wr),
        .dout (dout),
        .gnt  (gnt),
        .tmo  (tmo),
        .din  (din),
        .pad_i(pad_i),
        .pad_o(pad_o),
        .pad_t(pad_t)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus elapsed-cycle age, pad history as a queue.
    int       mPhase = M_IDLE;
    int       mOwner = 0;
    int       mLast  = 1;
    int       mAge   = 0;
    bit [1:0] mMask  = 2'b00;
    bit [1:0] mGnt   = 2'b00;
    bit       mTmo   = 1'b0;
    bit       mPadT  = 1'b1;
    bit       mPadO  = 1'b0;
    bit       padHist[$];

    typedef struct {
        bit       rstN;
        bit [1:0] req;
        bit [1:0] wr;
        bit [1:0] dout;
        bit       pad;
        bit [1:0] gnt;
        bit       tmo;
        bit       padT;
        bit       padO;
        bit       din;
    } vec_t;

    vec_t vecs[10];

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelStep();
        bit [1:0] nextMask;
        int       winner;
        if (!rst_n) begin
            mPhase  = M_IDLE;
            mOwner  = 0;
            mLast   = 1;
            mAge    = 0;
            mMask   = 2'b00;
            mTmo    = 1'b0;
            mPadT   = 1'b1;
            mPadO   = 1'b0;
            padHist = '{1'b0, 1'b0};
        end else begin
            padHist.push_back(pad_i);
            if (padHist.size() > 4) void'(padHist.pop_front());
            nextMask = mMask & req;
            mTmo  = 1'b0;
            mPadT = 1'b1;
            case (mPhase)
                M_IDLE: begin
                    winner = -1;
                    if (req[0] && !mMask[0] && req[1] && !mMask[1]) winner = 1 - mLast;
                    else if (req[0] && !mMask[0]) winner = 0;
                    else if (req[1] && !mMask[1]) winner = 1;
                    if (winner >= 0) begin
                        mPhase = M_TURN;
                        mOwner = winner;
                        mLast  = winner;
                        mAge   = 0;
                    end
                end
                M_TURN: begin
                    if (!req[mOwner]) mPhase = M_IDLE;
                    else if (mAge == TURN_CYC - 1) begin
                        mPhase = M_OWN;
                        mAge   = 0;
                    end else mAge++;
                end
                M_OWN: begin
                    if (!req[mOwner]) mPhase = M_REL;
                    else if (mAge == MAX_OWN - 1) begin
                        mPhase           = M_REL;
                        mTmo             = 1'b1;
                        nextMask[mOwner] = 1'b1;
                    end else begin
                        if (wr[mOwner]) begin
                            mPadT = 1'b0;
                            mPadO = dout[mOwner];
                        end
                        mAge++;
                    end
                end
                default: mPhase = M_IDLE;
            endcase
            mMask = nextMask;
        end
        mGnt = (mPhase == M_OWN) ? ((mOwner == 0) ? 2'b01 : 2'b10) : 2'b00;
    endtask

    task automatic applyStimulus(input bit r, input bit [1:0] rq, input bit [1:0] w,
                                 input bit [1:0] d, input bit p);
        rst_n = r;
        req   = rq;
        wr    = w;
        dout  = d;
        pad_i = p;
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".gnt"},   {6'd0, gnt},   {6'd0, mGnt});
        compare({tag, ".tmo"},   {7'd0, tmo},   {7'd0, mTmo});
        compare({tag, ".pad_t"}, {7'd0, pad_t}, {7'd0, mPadT});
        compare({tag, ".pad_o"}, {7'd0, pad_o}, {7'd0, mPadO});
        compare({tag, ".din"},   {7'd0, din},   {7'd0, padHist[padHist.size() - 2]});
    endtask

    task automatic stepCycle(input string tag);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        stepCycle("reset");
        rst_n = 1'b1;
    endtask

    task automatic waitGrant(input string name, input int limit, output int waited);
        waited = 0;
        while (gnt == 2'b00 && waited < limit) begin
            stepCycle(name);
            waited++;
        end
        checks++;
        if (gnt == 2'b00) begin
            errors++;
            $display("[TB] FAIL %s: no grant within %0d cycles, gnt=%b", name, limit, gnt);
        end
    endtask

    initial begin
        int waited;
        int ownCycles;
        int tmoCount;
        int regrants;
        bit [1:0] rq;

        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        vecs[0] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].req, vecs[i].wr, vecs[i].dout, vecs[i].pad);
            stepCycle($sformatf("vec%0d", i));
            compare($sformatf("vec%0d.tbl.gnt", i),   {6'd0, gnt},   {6'd0, vecs[i].gnt});
            compare($sformatf("vec%0d.tbl.tmo", i),   {7'd0, tmo},   {7'd0, vecs[i].tmo});
            compare($sformatf("vec%0d.tbl.pad_t", i), {7'd0, pad_t}, {7'd0, vecs[i].padT});
            compare($sformatf("vec%0d.tbl.pad_o", i), {7'd0, pad_o}, {7'd0, vecs[i].padO});
            compare($sformatf("vec%0d.tbl.din", i),   {7'd0, din},   {7'd0, vecs[i].din});
        end

        // Both requesting after reset: requester 0 first, then a guarded handover to 1.
        doReset();
        applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
        waitGrant("rr.first", 10, waited);
        compare("rr.first_gnt", {6'd0, gnt}, 8'h01);
        applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
        stepCycle("rr.release");
        compare("rr.release_gnt", {6'd0, gnt}, 8'h00);
        waitGrant("rr.second", 20, waited);
        compare("rr.second_gnt", {6'd0, gnt}, 8'h02);
        checks++;
        if (waited + 1 < TURN_CYC + 1) begin
            errors++;
            $display("[TB] FAIL rr.gap: got %0d idle cycles required at least %0d", waited + 1, TURN_CYC + 1);
        end

        // Held request hits the ownership limit and stays masked until it drops.
        doReset();
        applyStimulus(1'b1, 2'b01, 2'b01, 2'b01, 1'b0);
        waitGrant("tmo.grant", 10, waited);
        ownCycles = 0;
        tmoCount  = 0;
        while (gnt == 2'b01 && ownCycles < MAX_OWN + 4) begin
            ownCycles++;
            stepCycle("tmo.own");
            if (tmo) tmoCount++;
        end
        compare("tmo.own_cycles", 8'(ownCycles), 8'(MAX_OWN));
        regrants = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle("tmo.masked");
            if (tmo) tmoCount++;
            if (gnt != 2'b00) regrants++;
        end
        compare("tmo.pulse_count", 8'(tmoCount), 8'd1);
        compare("tmo.regrants", 8'(regrants), 8'd0);
        applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        stepCycle("tmo.drop");
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
        waitGrant("tmo.regrant", 10, waited);
        compare("tmo.regrant_gnt", {6'd0, gnt}, 8'h01);

        // Reset while driving the pad.
        doReset();
        applyStimulus(1'b1, 2'b01, 2'b01, 2'b00, 1'b1);
        waitGrant("rst.grant", 10, waited);
        stepCycle("rst.own");
        stepCycle("rst.own");
        compare("rst.pad_t_driving", {7'd0, pad_t}, 8'h00);
        applyStimulus(1'b0, 2'b01, 2'b01, 2'b00, 1'b1);
        stepCycle("rst.assert");
        compare("rst.pad_t", {7'd0, pad_t}, 8'h01);
        compare("rst.gnt", {6'd0, gnt}, 8'h00);
        applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
        waitGrant("rst.regrant", 10, waited);
        compare("rst.first_gnt", {6'd0, gnt}, 8'h01);

        // Randomized traffic with occasional resets.
        rq = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rq[0] = ~rq[0];
            if ($urandom_range(7) == 0) rq[1] = ~rq[1];
            applyStimulus(($urandom_range(199) != 0), rq, 2'($urandom), 2'($urandom), 1'($urandom));
            stepCycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
